// File: rtl/matrix_packer.sv
// rtl/matrix_packer.sv - packs an element stream into a matrix plus valid vector, double-buffered
module matrix_packer #(
    parameter int ELEM_W   = 4,
    parameter int NUM_ELEM = 5
) (
    input  logic                                 main_clk_i,
    input  logic                                 main_rst_an_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [ELEM_W-1:0]                    in_data_i,
    input  logic                                 in_last_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NUM_ELEM-1:0][ELEM_W-1:0]      out_matrix_o,
    output logic [NUM_ELEM-1:0]                  out_vec_o,
    output logic [$clog2(NUM_ELEM+1)-1:0]        out_cnt_o
);

    localparam int CNT_W = $clog2(NUM_ELEM + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

    // ST_FILL: accepting elements; ST_HOLD: a completed matrix waits in the fill slot
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_ELEM-1:0][ELEM_W-1:0] fill_mat;
    logic [NUM_ELEM-1:0]             fill_vec;
    logic [CNT_W-1:0]                fill_cnt;

    logic [NUM_ELEM-1:0][ELEM_W-1:0] fill_mat_next;
    logic [NUM_ELEM-1:0]             fill_vec_next;
    logic [CNT_W-1:0]                fill_cnt_next;

    logic accept;
    logic complete;
    logic out_free;
    logic transfer;

    // in_ready depends only on the state register, never on out_ready_i
    assign in_ready_o = (state == ST_FILL);

    // State register
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state, element insertion and fill-to-output transfer decision
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        complete      = 1'b0;
        transfer      = 1'b0;
        fill_mat_next = fill_mat;
        fill_vec_next = fill_vec;
        fill_cnt_next = fill_cnt;
        out_free      = !out_valid_o || out_ready_i;

        unique case (state)
            ST_FILL: begin
                accept = in_valid_i;
                if (accept) begin
                    for (int k = 0; k < NUM_ELEM; k++) begin
                        if (fill_cnt == CNT_W'(k)) begin
                            fill_mat_next[k] = in_data_i;
                            fill_vec_next[k] = 1'b1;
                        end
                    end
                    fill_cnt_next = fill_cnt + CNT_W'(1);
                    complete      = (fill_cnt == LAST_IDX) || in_last_i;
                end
                if (complete) begin
                    if (out_free) begin
                        transfer = 1'b1;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Fill slot contents are final; they move as soon as the output slot frees
                if (out_free) begin
                    transfer   = 1'b1;
                    state_next = ST_FILL;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Fill register: accumulate elements, clear when the matrix moves to the output slot
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            fill_mat <= '0;
            fill_vec <= '0;
            fill_cnt <= '0;
        end else if (transfer) begin
            fill_mat <= '0;
            fill_vec <= '0;
            fill_cnt <= '0;
        end else begin
            fill_mat <= fill_mat_next;
            fill_vec <= fill_vec_next;
            fill_cnt <= fill_cnt_next;
        end
    end

    // Output register: load on transfer (also back-to-back with a drain), zero when drained
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            out_valid_o  <= 1'b0;
            out_matrix_o <= '0;
            out_vec_o    <= '0;
            out_cnt_o    <= '0;
        end else if (transfer) begin
            out_valid_o  <= 1'b1;
            out_matrix_o <= fill_mat_next;
            out_vec_o    <= fill_vec_next;
            out_cnt_o    <= fill_cnt_next;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o  <= 1'b0;
            out_matrix_o <= '0;
            out_vec_o    <= '0;
            out_cnt_o    <= '0;
        end
    end

endmodule

// File: tb/tb_matrix_packer.sv
// tb/tb_matrix_packer.sv - self-checking bench for matrix_packer with a queue-level reference model
module tb_matrix_packer;

    localparam int EW = 4;
    localparam int NE = 5;
    localparam int MW = EW * NE;
    localparam int CW = $clog2(NE + 1);

    logic clk = 1'b0;
    logic rst_n;

    logic                   in_valid;
    logic                   in_ready;
    logic [EW-1:0]          in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [NE-1:0][EW-1:0]  out_matrix;
    logic [NE-1:0]          out_vec;
    logic [CW-1:0]          out_cnt;

    logic                   v2;
    logic                   rdy2;
    logic [7:0]             d2;
    logic                   l2;
    logic                   ov2;
    logic                   r2;
    logic [1:0][7:0]        om2;
    logic [1:0]             vec2;
    logic [1:0]             cnt2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [MW-1:0] mat;
        int            cnt;
    } mtx_t;

    mtx_t          pend[$];
    logic [EW-1:0] cur[$];

    // Clock generation
    always #5 clk = ~clk;

    matrix_packer #(.ELEM_W(EW), .NUM_ELEM(NE)) dut (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_matrix_o (out_matrix),
        .out_vec_o    (out_vec),
        .out_cnt_o    (out_cnt)
    );

    matrix_packer #(.ELEM_W(8), .NUM_ELEM(2)) dut2 (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .in_valid_i   (v2),
        .in_ready_o   (rdy2),
        .in_data_i    (d2),
        .in_last_i    (l2),
        .out_valid_o  (ov2),
        .out_ready_i  (r2),
        .out_matrix_o (om2),
        .out_vec_o    (vec2),
        .out_cnt_o    (cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mtx_t build();
        mtx_t m;
        m.mat = '0;
        m.cnt = cur.size();
        foreach (cur[k]) m.mat[k*EW +: EW] = cur[k];
        return m;
    endfunction

    task automatic check_model();
        logic [MW-1:0] em;
        int            ec;
        em = '0;
        ec = 0;
        if (pend.size() > 0) begin
            em = pend[0].mat;
            ec = pend[0].cnt;
        end
        chk("in_ready",   64'(in_ready),   64'(pend.size() < 2));
        chk("out_valid",  64'(out_valid),  64'(pend.size() > 0));
        chk("out_matrix", 64'(out_matrix), 64'(em));
        chk("out_vec",    64'(out_vec),    (64'd1 << ec) - 64'd1);
        chk("out_cnt",    64'(out_cnt),    64'(ec));
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model, check at the next falling edge
    task automatic cyc(input logic v, input logic [EW-1:0] d, input logic l, input logic r);
        bit rdy;
        rdy       = (pend.size() < 2);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        if (pend.size() > 0 && r) void'(pend.pop_front());
        if (v && rdy) begin
            cur.push_back(d);
            if (cur.size() == NE || l) begin
                pend.push_back(build());
                cur.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int nv;
        int nlow;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; d2 = '0; l2 = 1'b0; r2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_matrix", 64'(out_matrix), 64'd0);
        chk("rst_out_vec",    64'(out_vec),    64'd0);
        chk("rst_out_cnt",    64'(out_cnt),    64'd0);
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check_model();

        // Full matrix
        for (int i = 1; i <= 5; i++) cyc(1'b1, EW'(i), 1'b0, 1'b1);
        chk("full_matrix", 64'(out_matrix), 64'h54321);
        chk("full_vec",    64'(out_vec),    64'h1f);
        chk("full_cnt",    64'(out_cnt),    64'd5);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Early flush
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        cyc(1'b1, 4'hB, 1'b1, 1'b1);
        chk("flush_matrix", 64'(out_matrix), 64'h000BA);
        chk("flush_vec",    64'(out_vec),    64'h03);
        chk("flush_cnt",    64'(out_cnt),    64'd2);
        cyc(1'b1, 4'h0, 1'b0, 1'b1);
        chk("last_without_valid_ignored", 64'(out_valid), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("no_empty_matrix", 64'(out_valid), 64'd0);
        cyc(1'b1, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Backpressure
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, EW'(i), 1'b0, 1'b0);
            if (i >= 5) chk("bp_hold_matrix", 64'(out_matrix), 64'h43210);
        end
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        cyc(1'b1, 4'h3, 1'b0, 1'b1);
        chk("bp_valid_stays", 64'(out_valid),  64'd1);
        chk("bp_second",      64'(out_matrix), 64'h98765);
        chk("bp_ready_back",  64'(in_ready),   64'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back
        nv = 0;
        nlow = 0;
        for (int i = 0; i < 15; i++) begin
            if (in_ready !== 1'b1) nlow++;
            cyc(1'b1, EW'(i + 3), 1'b0, 1'b1);
            if (out_valid === 1'b1) nv++;
        end
        chk("b2b_pulses",    64'(nv),   64'd3);
        chk("b2b_no_bubble", 64'(nlow), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("b2b_pulse_end", 64'(out_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) < 7), EW'($urandom), 1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 1)));
        end
        cyc(1'b1, 4'h1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation with a held output and a partial fill
        for (int i = 0; i < 8; i++) cyc(1'b1, EW'(i + 8), 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid",  64'(out_valid),  64'd0);
        chk("async_rst_matrix", 64'(out_matrix), 64'd0);
        chk("async_rst_vec",    64'(out_vec),    64'd0);
        chk("async_rst_cnt",    64'(out_cnt),    64'd0);
        pend.delete();
        cur.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_model();
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'hF, 1'b0, 1'b1);
        chk("post_rst_matrix", 64'(out_matrix), 64'hFFFFF);
        chk("post_rst_cnt",    64'(out_cnt),    64'd5);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Parameter variant: 8-bit elements, two per matrix
        v2 = 1'b1; d2 = 8'h12; r2 = 1'b1;
        @(negedge clk);
        chk("p2_partial_valid", 64'(ov2), 64'd0);
        d2 = 8'h34;
        @(negedge clk);
        v2 = 1'b0;
        chk("p2_valid",  64'(ov2),  64'd1);
        chk("p2_matrix", 64'(om2),  64'h3412);
        chk("p2_vec",    64'(vec2), 64'h3);
        chk("p2_cnt",    64'(cnt2), 64'd2);
        @(negedge clk);
        chk("p2_drained", 64'(ov2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
